// File: rtl/lsu_ram_initiator.sv
// lsu_ram_initiator: single-outstanding bridge between a pipeline load/store
// port and a simple RAM controller (strobe in, data valid one cycle later).
// States: IDLE -> ISSUE -> (WAIT) -> RESP. Illegal sizes answer with an error
// without touching memory.
// Optional feature: define LSU_TIMEOUT_EN to bound WAIT to TIMEOUT cycles;
// on expiry the access completes with rsp_err=1 and zero data.
module lsu_ram_initiator #(
    parameter int  DEPTH     = 4096,
    parameter int  XLEN      = 32,
    parameter int  TIMEOUT   = 15,
    localparam int ADDRWIDTH = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst,

    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_we,
    input  logic [ADDRWIDTH-1:0] req_addr,
    input  logic [XLEN-1:0]      req_wdata,
    input  logic [1:0]           req_size,
    input  logic                 req_unsigned,

    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [XLEN-1:0]      rsp_rdata,
    output logic                 rsp_err,

    output logic [ADDRWIDTH-1:0] mem_addr,
    output logic [XLEN-1:0]      mem_wrData,
    output logic                 mem_wrEn,
    output logic                 mem_rdEn,
    output logic                 mem_byteEn,
    output logic                 mem_halfEn,
    output logic                 mem_wordEn,
    output logic                 mem_unsignedEn,
    input  logic [XLEN-1:0]      mem_dataIn,
    input  logic                 mem_outEn
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t                 r_state;
    state_t                 w_next;

    // Request fields latched at acceptance; they drive the RAM side directly
    // so address, data and qualifiers stay frozen for the whole access.
    logic                   r_we;
    logic [ADDRWIDTH-1:0]   r_addr;
    logic [XLEN-1:0]        r_wdata;
    logic                   r_byte;
    logic                   r_half;
    logic                   r_word;
    logic                   r_uns;

    logic [XLEN-1:0]        r_rdata;
    logic                   r_err;

    logic                   w_req_ready;
    logic                   w_rsp_valid;
    logic                   w_wr_en;
    logic                   w_rd_en;
    logic                   w_wait_expired;

`ifdef LSU_TIMEOUT_EN
    localparam int CNTW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic [CNTW-1:0]        r_wait_cnt;

    // Last WAIT cycle reached without read data.
    assign w_wait_expired = (r_wait_cnt == CNTW'(TIMEOUT - 1));

    // WAIT cycle counter: cleared while entering WAIT, advances each WAIT cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wait_cnt <= '0;
        end else if (r_state == S_ISSUE) begin
            r_wait_cnt <= '0;
        end else if (r_state == S_WAIT) begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
        end
    end
`else
    // Without the timeout WAIT only ends on read data; TIMEOUT is kept in the
    // parameter list so both builds share one instantiation template.
    logic w_unused_timeout;
    assign w_unused_timeout = (TIMEOUT != 0);
    assign w_wait_expired   = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            // NOTE: clocked state uses non-blocking assignments so every
            // register samples pre-edge values regardless of block ordering.
            r_state <= w_next;
        end
    end

    // Next-state decode and per-state handshake/strobe outputs.
    always_comb begin
        // NOTE: every output gets a default before the case so no path
        // leaves a value unassigned (which would infer a latch).
        w_next      = r_state;
        w_req_ready = 1'b0;
        w_rsp_valid = 1'b0;
        w_wr_en     = 1'b0;
        w_rd_en     = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_req_ready = 1'b1;
                if (req_valid) begin
                    w_next = (req_size == 2'b11) ? S_RESP : S_ISSUE;
                end
            end
            S_ISSUE: begin
                w_wr_en = r_we;
                w_rd_en = ~r_we;
                w_next  = r_we ? S_RESP : S_WAIT;
            end
            S_WAIT: begin
                if (mem_outEn || w_wait_expired) begin
                    w_next = S_RESP;
                end
            end
            S_RESP: begin
                w_rsp_valid = 1'b1;
                if (rsp_ready) begin
                    w_next = S_IDLE;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Request latch at acceptance and response capture in WAIT.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_byte  <= 1'b0;
            r_half  <= 1'b0;
            r_word  <= 1'b0;
            r_uns   <= 1'b0;
            r_rdata <= '0;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        r_we    <= req_we;
                        r_addr  <= req_addr;
                        r_wdata <= req_wdata;
                        r_byte  <= (req_size == 2'b00);
                        r_half  <= (req_size == 2'b01);
                        r_word  <= (req_size == 2'b10);
                        r_uns   <= req_unsigned;
                        // Stores and errors report zero data.
                        r_rdata <= '0;
                        r_err   <= (req_size == 2'b11);
                    end
                end
                S_WAIT: begin
                    if (mem_outEn) begin
                        r_rdata <= mem_dataIn;
                        r_err   <= 1'b0;
                    end else if (w_wait_expired) begin
                        r_rdata <= '0;
                        r_err   <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign req_ready      = w_req_ready;
    assign rsp_valid      = w_rsp_valid;
    assign rsp_rdata      = r_rdata;
    assign rsp_err        = r_err;

    assign mem_addr       = r_addr;
    assign mem_wrData     = r_wdata;
    assign mem_wrEn       = w_wr_en;
    assign mem_rdEn       = w_rd_en;
    assign mem_byteEn     = r_byte;
    assign mem_halfEn     = r_half;
    assign mem_wordEn     = r_word;
    assign mem_unsignedEn = r_uns;

endmodule

// File: tb/tb_lsu_ram_initiator.sv
// Testbench for lsu_ram_initiator: directed vector table, multi-cycle corner
// sequences (stale read data, reset during WAIT, WAIT without data) and
// randomized accesses against a behavioural transaction model.
module tb_lsu_ram_initiator;

    localparam int AW  = 12;
    localparam int XL  = 32;
    localparam int TMO = 15;

    logic          clk;
    logic          rst;
    logic          req_valid;
    logic          req_ready;
    logic          req_we;
    logic [AW-1:0] req_addr;
    logic [XL-1:0] req_wdata;
    logic [1:0]    req_size;
    logic          req_unsigned;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [XL-1:0] rsp_rdata;
    logic          rsp_err;
    logic [AW-1:0] mem_addr;
    logic [XL-1:0] mem_wrData;
    logic          mem_wrEn;
    logic          mem_rdEn;
    logic          mem_byteEn;
    logic          mem_halfEn;
    logic          mem_wordEn;
    logic          mem_unsignedEn;
    logic [XL-1:0] mem_dataIn;
    logic          mem_outEn;

    lsu_ram_initiator dut (
        .clk            (clk),
        .rst            (rst),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_we         (req_we),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .req_size       (req_size),
        .req_unsigned   (req_unsigned),
        .rsp_valid      (rsp_valid),
        .rsp_ready      (rsp_ready),
        .rsp_rdata      (rsp_rdata),
        .rsp_err        (rsp_err),
        .mem_addr       (mem_addr),
        .mem_wrData     (mem_wrData),
        .mem_wrEn       (mem_wrEn),
        .mem_rdEn       (mem_rdEn),
        .mem_byteEn     (mem_byteEn),
        .mem_halfEn     (mem_halfEn),
        .mem_wordEn     (mem_wordEn),
        .mem_unsignedEn (mem_unsignedEn),
        .mem_dataIn     (mem_dataIn),
        .mem_outEn      (mem_outEn)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    // RAM controller stand-in. A read strobe seen in one cycle yields
    // mem_outEn with ram_data in the next; inject_cnt forces an unsolicited
    // outEn pulse. Outside those pulses mem_dataIn carries junk.
    logic          ram_auto;
    logic [XL-1:0] ram_data;
    int            inject_cnt;
    int            inject_seen;

    initial begin : ram_responder
        logic pend;
        mem_outEn   = 1'b0;
        mem_dataIn  = '0;
        inject_seen = 0;
        forever begin
            @(negedge clk);
            #1;
            pend        = (ram_auto && mem_rdEn) || (inject_cnt != inject_seen);
            inject_seen = inject_cnt;
            @(posedge clk);
            #1;
            mem_outEn  = pend;
            mem_dataIn = pend ? ram_data : $urandom;
        end
    end

    // Expected outcome of one access, straight from the access rules:
    // illegal size answers with an error one edge after acceptance, stores
    // answer after two edges, loads (zero-wait RAM) after three.
    typedef struct {
        int          lat;
        logic        err;
        logic        b;
        logic        h;
        logic        w;
        logic [31:0] rdata;
    } exp_t;

    function automatic exp_t model(input logic we, input logic [1:0] size, input logic [31:0] ram);
        exp_t e;
        e.b = (size == 2'd0);
        e.h = (size == 2'd1);
        e.w = (size == 2'd2);
        if (size == 2'd3) begin
            e.lat = 1; e.err = 1'b1; e.rdata = '0;
        end else if (we) begin
            e.lat = 2; e.err = 1'b0; e.rdata = '0;
        end else begin
            e.lat = 3; e.err = 1'b0; e.rdata = ram;
        end
        return e;
    endfunction

    typedef struct {
        logic          we;
        logic [AW-1:0] addr;
        logic [31:0]   wdata;
        logic [1:0]    size;
        logic          uns;
        logic [31:0]   ram;
        int            hold;
        int            lat;
        logic          err;
        logic [31:0]   rdata;
        logic          b;
        logic          h;
        logic          w;
    } vec_t;

    vec_t tbl[8];

    task automatic scramble_req();
        req_we       = 1'($urandom);
        req_addr     = AW'($urandom);
        req_wdata    = $urandom;
        req_size     = 2'($urandom);
        req_unsigned = 1'($urandom);
    endtask

    // One full access: called at a negedge with the DUT idle; returns at a
    // negedge with the DUT idle again.
    task automatic run_txn(input logic we, input logic [AW-1:0] addr, input logic [31:0] wdata,
                           input logic [1:0] size, input logic uns, input logic [31:0] ram,
                           input int hold, input int exp_lat, input logic exp_err,
                           input logic [31:0] exp_rdata, input logic eb, input logic eh,
                           input logic ew);
        int          cyc;
        int          n_wr;
        int          n_rd;
        int          n_both;
        int          bad_q;
        int          bad_stable;
        int          bad_hold;
        logic [31:0] held_d;
        logic        held_e;
        logic        legal;
        legal    = (size != 2'd3);
        ram_data = ram;
        ram_auto = 1'b1;
        check("idle_ready", 32'(req_ready), 32'd1);
        req_valid    = 1'b1;
        req_we       = we;
        req_addr     = addr;
        req_wdata    = wdata;
        req_size     = size;
        req_unsigned = uns;
        rsp_ready    = 1'b0;
        @(negedge clk);
        req_valid = 1'b0;
        scramble_req();
        cyc = 1; n_wr = 0; n_rd = 0; n_both = 0; bad_q = 0; bad_stable = 0; bad_hold = 0;
        while (!rsp_valid && cyc < 40) begin
            if (mem_wrEn) n_wr++;
            if (mem_rdEn) n_rd++;
            if (mem_wrEn && mem_rdEn) n_both++;
            if (mem_wrEn || mem_rdEn) begin
                if (mem_addr != addr || mem_byteEn != eb || mem_halfEn != eh ||
                    mem_wordEn != ew || mem_unsignedEn != uns) bad_q++;
                if (we && mem_wrData != wdata) bad_q++;
            end
            if (legal && (mem_addr != addr || mem_wrData != wdata || mem_byteEn != eb ||
                          mem_halfEn != eh || mem_wordEn != ew || mem_unsignedEn != uns))
                bad_stable++;
            if (req_ready) bad_stable++;
            @(negedge clk);
            cyc++;
        end
        check("latency", 32'(cyc), 32'(exp_lat));
        check("rsp_err", 32'(rsp_err), 32'(exp_err));
        check("rsp_rdata", rsp_rdata, exp_rdata);
        held_d = rsp_rdata;
        held_e = rsp_err;
        if (hold > 0) begin
            req_valid = 1'b1;
            scramble_req();
        end
        for (int k = 0; k < hold; k++) begin
            @(negedge clk);
            if (!rsp_valid || rsp_rdata != held_d || rsp_err != held_e || req_ready ||
                mem_wrEn || mem_rdEn) bad_hold++;
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check("wr_strobes", 32'(n_wr), (legal && we) ? 32'd1 : 32'd0);
        check("rd_strobes", 32'(n_rd), (legal && !we) ? 32'd1 : 32'd0);
        check("wr_rd_overlap", 32'(n_both), 32'd0);
        check("strobe_qualifiers", 32'(bad_q), 32'd0);
        check("issue_wait_stable", 32'(bad_stable), 32'd0);
        check("resp_hold_stable", 32'(bad_hold), 32'd0);
        check("after_hs_valid", 32'(rsp_valid), 32'd0);
        check("after_hs_ready", 32'(req_ready), 32'd1);
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int   bad;
        int   cyc;
        exp_t e;
        logic we;
        logic [1:0] sz;
        logic [31:0] rd;

        // Directed vectors: {we, addr, wdata, size, uns, ram, hold, lat, err, rdata, b, h, w}
        tbl[0] = '{1'b1, 12'h010, 32'hDEADBEEF, 2'd2, 1'b0, 32'h0,        0, 2, 1'b0, 32'h0,        1'b0, 1'b0, 1'b1};
        tbl[1] = '{1'b0, 12'h020, 32'h0,        2'd0, 1'b0, 32'hFFFFFF80, 0, 3, 1'b0, 32'hFFFFFF80, 1'b1, 1'b0, 1'b0};
        tbl[2] = '{1'b1, 12'h030, 32'h13572468, 2'd3, 1'b0, 32'h0,        0, 1, 1'b1, 32'h0,        1'b0, 1'b0, 1'b0};
        tbl[3] = '{1'b0, 12'hFFF, 32'h0,        2'd2, 1'b0, 32'h12345678, 5, 3, 1'b0, 32'h12345678, 1'b0, 1'b0, 1'b1};
        tbl[4] = '{1'b0, 12'h000, 32'h0,        2'd1, 1'b1, 32'h0000BEEF, 2, 3, 1'b0, 32'h0000BEEF, 1'b0, 1'b1, 1'b0};
        tbl[5] = '{1'b1, 12'h7FF, 32'h000000A5, 2'd0, 1'b1, 32'h0,        1, 2, 1'b0, 32'h0,        1'b1, 1'b0, 1'b0};
        tbl[6] = '{1'b0, 12'h055, 32'h0,        2'd3, 1'b1, 32'h77777777, 3, 1, 1'b1, 32'h0,        1'b0, 1'b0, 1'b0};
        tbl[7] = '{1'b1, 12'h800, 32'h0000CAFE, 2'd1, 1'b0, 32'h0,        0, 2, 1'b0, 32'h0,        1'b0, 1'b1, 1'b0};

        rst          = 1'b1;
        req_valid    = 1'b0;
        req_we       = 1'b0;
        req_addr     = '0;
        req_wdata    = '0;
        req_size     = '0;
        req_unsigned = 1'b0;
        rsp_ready    = 1'b0;
        ram_auto     = 1'b1;
        ram_data     = '0;
        inject_cnt   = 0;

        // Reset state.
        repeat (3) @(negedge clk);
        check("rst_req_ready", 32'(req_ready), 32'd1);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_err", 32'(rsp_err), 32'd0);
        check("rst_rsp_rdata", rsp_rdata, 32'd0);
        check("rst_mem_addr", 32'(mem_addr), 32'd0);
        check("rst_mem_wrData", mem_wrData, 32'd0);
        check("rst_strobes", 32'({mem_wrEn, mem_rdEn}), 32'd0);
        check("rst_enables", 32'({mem_byteEn, mem_halfEn, mem_wordEn, mem_unsignedEn}), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Unsolicited read data while idle must not produce a response.
        ram_data = 32'h11112222;
        inject_cnt++;
        bad = 0;
        repeat (3) begin
            @(negedge clk);
            if (rsp_valid || !req_ready) bad++;
        end
        check("stale_outen_idle", 32'(bad), 32'd0);

        // Directed table.
        for (int i = 0; i < 8; i++) begin
            run_txn(tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].size, tbl[i].uns, tbl[i].ram,
                    tbl[i].hold, tbl[i].lat, tbl[i].err, tbl[i].rdata, tbl[i].b, tbl[i].h, tbl[i].w);
        end

        // Reset while waiting for read data, with outEn arriving just after.
        ram_auto     = 1'b0;
        ram_data     = 32'hBAD0BAD0;
        req_valid    = 1'b1;
        req_we       = 1'b0;
        req_addr     = 12'h123;
        req_size     = 2'd2;
        req_unsigned = 1'b0;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        check("wait_no_rsp", 32'(rsp_valid), 32'd0);
        rst = 1'b1;
        inject_cnt++;
        @(negedge clk);
        rst = 1'b0;
        bad = 0;
        repeat (4) begin
            if (rsp_valid || mem_rdEn || mem_wrEn || !req_ready) bad++;
            @(negedge clk);
        end
        check("rst_in_wait_no_rsp", 32'(bad), 32'd0);
        check("rst_in_wait_rdata", rsp_rdata, 32'd0);
        check("rst_in_wait_err", 32'(rsp_err), 32'd0);
        e = model(1'b0, 2'd2, 32'hC0FFEE01);
        run_txn(1'b0, 12'h124, 32'h0, 2'd2, 1'b0, 32'hC0FFEE01, 0, e.lat, e.err, e.rdata, e.b, e.h, e.w);

        // Load whose read data never arrives on its own.
        ram_auto     = 1'b0;
        req_valid    = 1'b1;
        req_we       = 1'b0;
        req_addr     = 12'h0AA;
        req_size     = 2'd2;
        req_unsigned = 1'b0;
        @(negedge clk);
        req_valid = 1'b0;
        cyc = 1;
`ifdef LSU_TIMEOUT_EN
        while (!rsp_valid && cyc < 60) begin
            @(negedge clk);
            cyc++;
        end
        check("timeout_latency", 32'(cyc), 32'(TMO + 2));
        check("timeout_err", 32'(rsp_err), 32'd1);
        check("timeout_rdata", rsp_rdata, 32'd0);
`else
        bad = 0;
        repeat (30) begin
            @(negedge clk);
            if (rsp_valid) bad++;
        end
        check("wait_persists", 32'(bad), 32'd0);
        ram_data = 32'h5A5A0001;
        inject_cnt++;
        cyc = 0;
        while (!rsp_valid && cyc < 5) begin
            @(negedge clk);
            cyc++;
        end
        check("late_data_latency", 32'(cyc), 32'd2);
        check("late_data_rdata", rsp_rdata, 32'h5A5A0001);
        check("late_data_err", 32'(rsp_err), 32'd0);
`endif
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        ram_auto  = 1'b1;
        check("wait_exit_idle", 32'(req_ready), 32'd1);

        // Randomized accesses against the model.
        for (int i = 0; i < 150; i++) begin
            we = 1'($urandom);
            sz = ($urandom_range(0, 7) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            rd = $urandom;
            e  = model(we, sz, rd);
            run_txn(we, AW'($urandom), $urandom, sz, 1'($urandom), rd, $urandom_range(0, 3),
                    e.lat, e.err, e.rdata, e.b, e.h, e.w);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/lsu_ram_initiator.md
LSU_RAM_INITIATOR -- requirements
Module: lsu_ram_initiator

Interface
REQ-001 SHALL have parameter DEPTH, default 4096, RAM depth in words; ADDRWIDTH = $clog2(DEPTH).
REQ-002 SHALL have parameter XLEN, default 32, data width.
REQ-003 SHALL have parameter TIMEOUT, default 15, max WAIT cycles (used only with LSU_TIMEOUT_EN).
REQ-004 SHALL have ports (name  direction  width  meaning):
 clk  in  1  single clock, rising edge
 rst  in  1  reset, synchronous, active-high
 req_valid  in  1  pipeline access request
 req_ready  out  1  request accepted when valid&ready
 req_we  in  1  1=store, 0=load
 req_addr  in  ADDRWIDTH  word address
 req_wdata  in  XLEN  store data, lane-0 aligned
 req_size  in  2  00 byte, 01 half, 10 word, 11 illegal
 req_unsigned  in  1  zero-extend load
 rsp_valid  out  1  response available
 rsp_ready  in  1  response consumed when valid&ready
 rsp_rdata  out  XLEN  load data (0 for stores/errors)
 rsp_err  out  1  access failed
 mem_addr  out  ADDRWIDTH  to RAM controller addr
 mem_wrData  out  XLEN  to RAM controller wrData
 mem_wrEn  out  1  write strobe
 mem_rdEn  out  1  read strobe
 mem_byteEn / mem_halfEn / mem_wordEn / mem_unsignedEn  out  1 each  size/sign qualifiers
 mem_dataIn  in  XLEN  from RAM controller dataOut
 mem_outEn  in  1  read data valid, one cycle after rdEn

Function
REQ-005 SHALL implement FSM states IDLE, ISSUE, WAIT, RESP; req_ready=1 only in IDLE.
REQ-006 IDLE: on req_valid, latch we/addr/wdata/size/unsigned; size 11 -> RESP with rsp_err=1, no memory strobe; else -> ISSUE.
REQ-007 ISSUE: assert exactly one cycle of mem_wrEn (store) or mem_rdEn (load); store -> RESP, load -> WAIT.
REQ-008 mem_addr, mem_wrData, mem_byteEn/halfEn/wordEn/unsignedEn SHALL be driven from latched registers and held stable from ISSUE through WAIT; exactly one of byteEn/halfEn/wordEn high per legal size.
REQ-009 WAIT: on mem_outEn=1 capture mem_dataIn into rsp_rdata, rsp_err=0, -> RESP.
REQ-010 RESP: rsp_valid=1, rsp_rdata/rsp_err stable until rsp_ready; on valid&ready -> IDLE (next request accepted the following cycle).
REQ-011 Latency from acceptance edge: store rsp_valid after 2 cycles, load after 3 cycles (zero-wait RAM).
REQ-012 mem_outEn outside WAIT SHALL be ignored.
REQ-013 mem_wrEn and mem_rdEn SHALL never be high simultaneously, and SHALL be low outside ISSUE.

Reset
REQ-014 On rst=1 at a clock edge: state IDLE; rsp_valid, rsp_err, mem_wrEn, mem_rdEn, enables = 0; rsp_rdata, mem_addr, mem_wrData = 0; timeout counter = 0.
REQ-015 Reset mid-operation SHALL abandon the access without response; a subsequent stale mem_outEn SHALL be ignored.

Configuration
REQ-016 Macro LSU_TIMEOUT_EN defined: WAIT counts cycles; if mem_outEn absent for TIMEOUT cycles -> RESP with rsp_err=1, rsp_rdata=0; counter clears on entering WAIT.
REQ-017 Macro undefined: no counter; WAIT persists until mem_outEn.

Verification
REQ-018 Store: req addr=0x010, wdata=0xDEADBEEF, size=10 -> one-cycle mem_wrEn with wordEn=1, rsp_valid 2 cycles later, rsp_err=0.
REQ-019 Load byte signed: RAM returns 0xFFFFFF80 with outEn -> rsp_rdata=0xFFFFFF80, byteEn=1, unsignedEn=0, rsp_valid 3 cycles after acceptance.
REQ-020 Illegal size 11 -> no mem_wrEn/mem_rdEn, rsp_err=1 next cycle.
REQ-021 rsp_ready held low 5 cycles -> rsp_valid/rsp_rdata stable, req_ready=0 throughout.
REQ-022 rst asserted in WAIT, outEn next cycle -> IDLE, no rsp_valid.
REQ-023 With LSU_TIMEOUT_EN, TIMEOUT=15, outEn never asserted -> rsp_err=1 after 15 WAIT cycles.
